// File: rtl/ikaopll_write_scheduler.sv
// Host write FIFO replayed onto the OPLL CS_n/WR_n/A0/D bus with phiM-counted strobe and wait times.
// Optional: define IKAOPLL_WRSCHED_ADDR_SKIP_EN to skip the address cycle when it repeats the last address.
module ikaopll_write_scheduler #(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int STB_LEN         = 2,
  parameter int ADDR_WAIT       = 12,
  parameter int DATA_WAIT       = 84
) (
  input  logic                     i_EMUCLK,
  input  logic                     i_RST,
  input  logic                     i_phiM_PCEN_n,
  input  logic                     i_FLUSH,
  input  logic                     i_WR_VALID,
  input  logic [7:0]               i_WR_ADDR,
  input  logic [7:0]               i_WR_DATA,
  output logic                     o_WR_READY,
  output logic [FIFO_DEPTH_LOG2:0] o_LEVEL,
  output logic                     o_BUSY,
  output logic                     o_CS_n,
  output logic                     o_WR_n,
  output logic                     o_A0,
  output logic [7:0]               o_D
);

  localparam int PW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [6:0] STB_RELOAD   = 7'(STB_LEN - 1);
  localparam logic [6:0] AWAIT_RELOAD = 7'(ADDR_WAIT - 1);
  localparam logic [6:0] DWAIT_RELOAD = 7'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ASTB,
    AWAIT,
    DSTB,
    DWAIT
  } state_t;

  logic [7:0]    addr_mem [DEPTH];
  logic [7:0]    data_mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          tick;
  logic [7:0]    rd_addr;
  logic [7:0]    rd_data;
  logic          skip;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] cnt;
  logic [6:0] cnt_nxt;
  logic       strobe_n;
  logic       strobe_n_nxt;
  logic       a0;
  logic       a0_nxt;
  logic [7:0] bus_d;
  logic [7:0] bus_d_nxt;
  logic [7:0] hold_data;
  logic [7:0] hold_data_nxt;

  assign tick    = ~i_phiM_PCEN_n;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
  assign push    = i_WR_VALID & ~full;
  assign rd_addr = addr_mem[rptr[PW-2:0]];
  assign rd_data = data_mem[rptr[PW-2:0]];

  always_ff @(posedge i_EMUCLK) begin
    if (push) begin
      addr_mem[wptr[PW-2:0]] <= i_WR_ADDR;
      data_mem[wptr[PW-2:0]] <= i_WR_DATA;
    end
  end

  // Flush drops only queued entries; a push on the same edge lands after the old wptr and survives.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (i_FLUSH) begin
        rptr <= wptr;
      end else if (pop) begin
        rptr <= rptr + PW'(1);
      end
    end
  end

`ifdef IKAOPLL_WRSCHED_ADDR_SKIP_EN
  logic [7:0] last_addr;
  logic       last_valid;

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      last_addr  <= '0;
      last_valid <= 1'b0;
    end else if (tick && (state == ASTB) && (cnt == 7'd0)) begin
      last_addr  <= bus_d;
      last_valid <= 1'b1;
    end
  end

  assign skip = last_valid && (rd_addr == last_addr);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      state     <= IDLE;
      cnt       <= '0;
      strobe_n  <= 1'b1;
      a0        <= 1'b0;
      bus_d     <= '0;
      hold_data <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      strobe_n  <= strobe_n_nxt;
      a0        <= a0_nxt;
      bus_d     <= bus_d_nxt;
      hold_data <= hold_data_nxt;
    end
  end

  // Bus sequencer only moves on phiM-enabled edges; A0/D are left alone while strobes are high.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    strobe_n_nxt  = strobe_n;
    a0_nxt        = a0;
    bus_d_nxt     = bus_d;
    hold_data_nxt = hold_data;
    pop           = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop          = 1'b1;
            strobe_n_nxt = 1'b0;
            cnt_nxt      = STB_RELOAD;
            if (skip) begin
              a0_nxt    = 1'b1;
              bus_d_nxt = rd_data;
              state_nxt = DSTB;
            end else begin
              a0_nxt        = 1'b0;
              bus_d_nxt     = rd_addr;
              hold_data_nxt = rd_data;
              state_nxt     = ASTB;
            end
          end
        end
        ASTB: begin
          if (cnt == 7'd0) begin
            strobe_n_nxt = 1'b1;
            cnt_nxt      = AWAIT_RELOAD;
            state_nxt    = AWAIT;
          end else begin
            cnt_nxt = cnt - 7'd1;
          end
        end
        AWAIT: begin
          if (cnt == 7'd0) begin
            a0_nxt       = 1'b1;
            bus_d_nxt    = hold_data;
            strobe_n_nxt = 1'b0;
            cnt_nxt      = STB_RELOAD;
            state_nxt    = DSTB;
          end else begin
            cnt_nxt = cnt - 7'd1;
          end
        end
        DSTB: begin
          if (cnt == 7'd0) begin
            strobe_n_nxt = 1'b1;
            cnt_nxt      = DWAIT_RELOAD;
            state_nxt    = DWAIT;
          end else begin
            cnt_nxt = cnt - 7'd1;
          end
        end
        DWAIT: begin
          if (cnt == 7'd0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 7'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign o_WR_READY = ~full;
  assign o_LEVEL    = wptr - rptr;
  assign o_BUSY     = (state != IDLE) || !empty;
  assign o_CS_n     = strobe_n;
  assign o_WR_n     = strobe_n;
  assign o_A0       = a0;
  assign o_D        = bus_d;

endmodule

// File: tb/tb_ikaopll_write_scheduler.sv
// Scoreboard bench for ikaopll_write_scheduler: expected bus strobes are queued at push time and
// checked (content, width, gaps) by a monitor as the DUT drives CS_n low.
module tb_ikaopll_write_scheduler;

  localparam int STB     = 2;
  localparam int AW      = 12;
  localparam int DW      = 84;
  localparam int SPACING = 2 * STB + AW + DW + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pcen_n = 1'b1;
  logic       flush = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic [3:0] level;
  logic       busy;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] d;

  ikaopll_write_scheduler dut (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_phiM_PCEN_n (pcen_n),
    .i_FLUSH       (flush),
    .i_WR_VALID    (wr_valid),
    .i_WR_ADDR     (wr_addr),
    .i_WR_DATA     (wr_data),
    .o_WR_READY    (wr_ready),
    .o_LEVEL       (level),
    .o_BUSY        (busy),
    .o_CS_n        (cs_n),
    .o_WR_n        (wr_n),
    .o_A0          (a0),
    .o_D           (d)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // phiM enable on every 4th clock when phi_en is set; otherwise tasks drive pcen_n by hand
  int phase = 0;
  bit phi_en = 1'b1;
  always @(negedge clk) begin
    if (phi_en) begin
      phase  = (phase + 1) % 4;
      pcen_n = (phase != 0);
    end
  end

  logic [8:0] sb[$];
  logic [8:0] exp_e;
  int  tick_cnt = 0;
  bit  mon_en = 1'b0;
  bit  prev_cs = 1'b1;
  bit  last_was_addr = 1'b0;
  int  last_fall = 0;
  int  last_rise = 0;
  int  last_gap = 0;
  int  addr_fall_tick = 0;
  bit  addr_fall_valid = 1'b0;
  bit  check_spacing = 1'b0;

  // Monitor: counts phiM ticks and checks every strobe against the scoreboard
  always begin
    @(posedge clk);
    if (pcen_n === 1'b0) tick_cnt++;
    #1;
    if (mon_en) begin
      if (prev_cs && cs_n === 1'b0) begin
        tests++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_strobe: got a0=%0b d=%02h, required no strobe", a0, d);
        end else begin
          exp_e = sb.pop_front();
          if ({a0, d} !== exp_e || wr_n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL strobe_content: got a0=%0b d=%02h wr_n=%0b, required a0=%0b d=%02h wr_n=0",
                     a0, d, wr_n, exp_e[8], exp_e[7:0]);
          end
        end
        last_gap = tick_cnt - last_rise;
        if (a0 === 1'b1 && last_was_addr) begin
          tests++;
          if (last_gap !== AW) begin
            failures++;
            $display("[TB] FAIL addr_to_data_gap: got %0d ticks, required %0d", last_gap, AW);
          end
        end
        if (a0 === 1'b0) begin
          if (check_spacing && addr_fall_valid) begin
            tests++;
            if (tick_cnt - addr_fall_tick !== SPACING) begin
              failures++;
              $display("[TB] FAIL addr_spacing: got %0d ticks, required %0d", tick_cnt - addr_fall_tick, SPACING);
            end
          end
          addr_fall_tick  = tick_cnt;
          addr_fall_valid = 1'b1;
        end
        last_was_addr = (a0 === 1'b0);
        last_fall     = tick_cnt;
      end else if (!prev_cs && cs_n === 1'b1) begin
        tests++;
        if (tick_cnt - last_fall !== STB || wr_n !== 1'b1) begin
          failures++;
          $display("[TB] FAIL strobe_width: got %0d ticks wr_n=%0b, required %0d ticks wr_n=1",
                   tick_cnt - last_fall, wr_n, STB);
        end
        last_rise = tick_cnt;
      end
    end
    prev_cs = (cs_n === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_entry(input logic [7:0] a, input logic [7:0] dt, input bit skip_addr);
    int guard = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = dt;
    while (wr_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      tests++;
      failures++;
      $display("[TB] FAIL push_timeout: got ready=%0b, required 1", wr_ready);
    end else begin
      if (!skip_addr) sb.push_back({1'b0, a});
      sb.push_back({1'b1, dt});
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy !== 1'b0 && n < bound);
    if (busy !== 1'b0) begin
      tests++;
      failures++;
      $display("[TB] FAIL idle_timeout: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic wait_cs(input logic v);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cs_n !== v && n < 2000);
    if (cs_n !== v) begin
      tests++;
      failures++;
      $display("[TB] FAIL cs_timeout: got cs_n=%0b, required %0b", cs_n, v);
    end
  endtask

  task automatic stop_phi();
    phi_en = 1'b0;
    @(negedge clk);
    #1;
    pcen_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (sb.size() != 0 || level !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_drain: got pending=%0d level=%0d busy=%0b, required 0/0/0", name, sb.size(), level, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({wr_ready, level, busy, cs_n, wr_n, a0, d} !== {1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("[TB] FAIL reset_values: got ready=%0b level=%0d busy=%0b cs=%0b wr=%0b a0=%0b d=%02h, required 1/0/0/1/1/0/00",
               wr_ready, level, busy, cs_n, wr_n, a0, d);
    end
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int push_tick;
    check_spacing = 1'b0;
    push_entry(8'h10, 8'h55, 1'b0);
    push_tick = tick_cnt;
    tests++;
    if (level !== 4'd1) begin
      failures++;
      $display("[TB] FAIL single_level: got %0d, required 1", level);
    end
    wait_cs(1'b0);
    tests++;
    if (tick_cnt - push_tick !== 1) begin
      failures++;
      $display("[TB] FAIL single_latency: got %0d ticks, required 1", tick_cnt - push_tick);
    end
    wait_idle(2000);
    tests++;
    if (tick_cnt - last_rise !== DW) begin
      failures++;
      $display("[TB] FAIL busy_fall: got %0d ticks after data release, required %0d", tick_cnt - last_rise, DW);
    end
    tests++;
    if (a0 !== 1'b1 || d !== 8'h55) begin
      failures++;
      $display("[TB] FAIL bus_hold: got a0=%0b d=%02h, required a0=1 d=55", a0, d);
    end
    check_drained("single");
  endtask

  task automatic test_back_to_back();
    stop_phi();
    check_spacing   = 1'b1;
    addr_fall_valid = 1'b0;
    for (int i = 0; i < 8; i++) push_entry(8'h30 + 8'(i), 8'hA0 + 8'(i), 1'b0);
    tests++;
    if (wr_ready !== 1'b0 || level !== 4'd8) begin
      failures++;
      $display("[TB] FAIL full_flag: got ready=%0b level=%0d, required 0/8", wr_ready, level);
    end
    phi_en = 1'b1;
    push_entry(8'h38, 8'hA8, 1'b0);
    tests++;
    if (level !== 4'd8) begin
      failures++;
      $display("[TB] FAIL ninth_accept: got level=%0d, required 8", level);
    end
    wait_idle(20000);
    check_drained("back_to_back");
    check_spacing = 1'b0;
  endtask

  task automatic test_flush();
    stop_phi();
    for (int i = 0; i < 4; i++) push_entry(8'h40 + 8'(i), 8'hB0 + 8'(i), 1'b0);
    phi_en = 1'b1;
    wait_cs(1'b0);
    wait_cs(1'b1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    tests++;
    if (level !== 4'd0) begin
      failures++;
      $display("[TB] FAIL flush_level: got %0d, required 0", level);
    end
    while (sb.size() > 1) void'(sb.pop_back());
    wait_idle(2000);
    repeat (400) @(posedge clk);
    #1;
    check_drained("flush");
  endtask

  task automatic test_simultaneous();
    stop_phi();
    addr_fall_valid = 1'b0;
    check_spacing   = 1'b1;
    for (int i = 0; i < 4; i++) push_entry(8'h50 + 8'(i), 8'hC0 + 8'(i), 1'b0);
    tests++;
    if (level !== 4'd4) begin
      failures++;
      $display("[TB] FAIL simul_prefill: got level=%0d, required 4", level);
    end
    @(negedge clk);
    #1;
    pcen_n   = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 8'h54;
    wr_data  = 8'hC4;
    sb.push_back({1'b0, 8'h54});
    sb.push_back({1'b1, 8'hC4});
    @(posedge clk);
    #1;
    pcen_n   = 1'b1;
    wr_valid = 1'b0;
    tests++;
    if (level !== 4'd4 || cs_n !== 1'b0) begin
      failures++;
      $display("[TB] FAIL simul_level: got level=%0d cs_n=%0b, required 4/0", level, cs_n);
    end
    phi_en = 1'b1;
    wait_idle(20000);
    check_drained("simultaneous");
    check_spacing = 1'b0;
  endtask

  task automatic test_reset_mid();
    push_entry(8'h60, 8'hD0, 1'b0);
    push_entry(8'h61, 8'hD1, 1'b0);
    do wait_cs(1'b0); while (a0 !== 1'b1 && tick_cnt < 1_000_000);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    tests++;
    if ({cs_n, wr_n, level, busy, a0, d} !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("[TB] FAIL async_reset: got cs=%0b wr=%0b level=%0d busy=%0b a0=%0b d=%02h, required 1/1/0/0/0/00",
               cs_n, wr_n, level, busy, a0, d);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check_drained("reset_mid");
  endtask

`ifdef IKAOPLL_WRSCHED_ADDR_SKIP_EN
  task automatic test_addr_skip();
    push_entry(8'h20, 8'h11, 1'b0);
    push_entry(8'h20, 8'h22, 1'b1);
    wait_idle(2000);
    tests++;
    if (last_gap !== DW + 1) begin
      failures++;
      $display("[TB] FAIL skip_gap: got %0d ticks, required %0d", last_gap, DW + 1);
    end
    check_drained("addr_skip");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_simultaneous();
    test_reset_mid();
`ifdef IKAOPLL_WRSCHED_ADDR_SKIP_EN
    test_addr_skip();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
